// File: rtl/lotr_pkg.sv
// Shared LOTR ring definitions: opcodes, packet layout and the ID field inside
// the address. Tile ring controllers and ring stops both import this.
package lotr_pkg;

  typedef enum logic [1:0] {
    OP_RD     = 2'b00,
    OP_WR     = 2'b01,
    OP_RD_RSP = 2'b10,
    OP_WR_RSP = 2'b11
  } ring_op_e;

  // Address[31:24]: target ID on requests, requester ID on responses.
  localparam int ID_MSB = 31;
  localparam int ID_LSB = 24;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [31:0] address;
    logic [31:0] data;
  } ring_pkt_t;

  function automatic logic [7:0] ring_id(input logic [31:0] address);
    return address[ID_MSB:ID_LSB];
  endfunction

  function automatic logic is_rsp(input logic [1:0] opcode);
    return (opcode == OP_RD_RSP) || (opcode == OP_WR_RSP);
  endfunction

endpackage

// File: rtl/ring_host_req_fifo.sv
// Small synchronous FIFO holding host requests until a free ring slot appears.
// Head is presented combinationally; pointers carry a wrap bit for full/empty.
module ring_host_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ring_host_stop.sv
// Host ring stop: one-cycle registered hop between two tiles, ejecting host
// responses into a single-entry buffer and injecting queued host requests.
module ring_host_stop
  import lotr_pkg::*;
#(
  parameter logic [7:0] HOST_ID         = 8'hFF,
  parameter int         REQ_DEPTH       = 4,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic        QClk,
  input  logic        RstQnnnL,
  input  logic        RingInputValidQ500H,
  input  logic [1:0]  RingInputOpcodeQ500H,
  input  logic [31:0] RingInputAddressQ500H,
  input  logic [31:0] RingInputDataQ500H,
  output logic        RingOutputValidQ501H,
  output logic [1:0]  RingOutputOpcodeQ501H,
  output logic [31:0] RingOutputAddressQ501H,
  output logic [31:0] RingOutputDataQ501H,
  input  logic        HostReqValid,
  output logic        HostReqReady,
  input  logic [1:0]  HostReqOpcode,
  input  logic [31:0] HostReqAddress,
  input  logic [31:0] HostReqData,
  output logic        HostRspValid,
  input  logic        HostRspReady,
  output logic [1:0]  HostRspOpcode,
  output logic [31:0] HostRspAddress,
  output logic [31:0] HostRspData,
  output logic [15:0] RecircCnt
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  ring_pkt_t        in_pkt;
  ring_pkt_t        req_head;
  ring_pkt_t        out_pkt;
  ring_pkt_t        rsp_pkt;
  logic             out_valid;
  logic             rsp_valid;
  logic [OUT_W-1:0] outstanding;
  logic             req_full;
  logic             req_empty;
  logic             req_push;
  logic             eject_hit;
  logic             rsp_pop;
  logic             eject;
  logic             recirc;
  logic             slot_empty;
  logic             inject;

  assign in_pkt = {RingInputOpcodeQ500H, RingInputAddressQ500H, RingInputDataQ500H};

  // Response-type host requests are acknowledged but never queued.
  assign HostReqReady = !req_full;
  assign req_push     = HostReqValid && HostReqReady && !is_rsp(HostReqOpcode);

  ring_host_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH ($bits(ring_pkt_t))
  ) u_req_fifo (
    .clk       (QClk),
    .rst_n     (RstQnnnL),
    .push      (req_push),
    .push_data ({HostReqOpcode, HostReqAddress, HostReqData}),
    .pop       (inject),
    .head      (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  assign eject_hit  = RingInputValidQ500H && is_rsp(RingInputOpcodeQ500H) &&
                      (ring_id(RingInputAddressQ500H) == HOST_ID);
  assign rsp_pop    = rsp_valid && HostRspReady;
  assign eject      = eject_hit && (!rsp_valid || rsp_pop);
  assign recirc     = eject_hit && !eject;
  assign slot_empty = !RingInputValidQ500H || eject;
  assign inject     = slot_empty && !req_empty &&
                      (outstanding < OUT_W'(MAX_OUTSTANDING));

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else begin
      out_valid <= inject || (RingInputValidQ500H && !eject);
      out_pkt   <= inject ? req_head : in_pkt;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      rsp_valid <= 1'b0;
      rsp_pkt   <= '0;
    end else if (eject) begin
      rsp_valid <= 1'b1;
      rsp_pkt   <= in_pkt;
    end else if (rsp_pop) begin
      rsp_valid <= 1'b0;
    end
  end

  // Decrement floors at zero so responses to pre-reset requests are harmless.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      outstanding <= '0;
    end else if (inject && !eject) begin
      outstanding <= outstanding + 1'b1;
    end else if (eject && !inject && (outstanding != '0)) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      RecircCnt <= '0;
    end else if (recirc && (RecircCnt != 16'hFFFF)) begin
      RecircCnt <= RecircCnt + 16'd1;
    end
  end

  assign RingOutputValidQ501H   = out_valid;
  assign RingOutputOpcodeQ501H  = out_pkt.opcode;
  assign RingOutputAddressQ501H = out_pkt.address;
  assign RingOutputDataQ501H    = out_pkt.data;

  assign HostRspValid   = rsp_valid;
  assign HostRspOpcode  = rsp_pkt.opcode;
  assign HostRspAddress = rsp_pkt.address;
  assign HostRspData    = rsp_pkt.data;

  req_opcode_legal: assert property (@(posedge QClk) disable iff (!RstQnnnL)
    (HostReqValid && HostReqReady) |-> !is_rsp(HostReqOpcode));

endmodule

// File: tb/tb_ring_host_stop.sv
// Scoreboard bench for ring_host_stop: directed ring/host stimulus pushes the
// expected ring and host-response packets, a monitor pops and compares them.
module tb_ring_host_stop;
  import lotr_pkg::*;

  logic        QClk = 1'b0;
  logic        RstQnnnL;
  logic        RingInputValidQ500H;
  logic [1:0]  RingInputOpcodeQ500H;
  logic [31:0] RingInputAddressQ500H;
  logic [31:0] RingInputDataQ500H;
  logic        RingOutputValidQ501H;
  logic [1:0]  RingOutputOpcodeQ501H;
  logic [31:0] RingOutputAddressQ501H;
  logic [31:0] RingOutputDataQ501H;
  logic        HostReqValid;
  logic        HostReqReady;
  logic [1:0]  HostReqOpcode;
  logic [31:0] HostReqAddress;
  logic [31:0] HostReqData;
  logic        HostRspValid;
  logic        HostRspReady;
  logic [1:0]  HostRspOpcode;
  logic [31:0] HostRspAddress;
  logic [31:0] HostRspData;
  logic [15:0] RecircCnt;

  ring_host_stop dut (
    .QClk                   (QClk),
    .RstQnnnL               (RstQnnnL),
    .RingInputValidQ500H    (RingInputValidQ500H),
    .RingInputOpcodeQ500H   (RingInputOpcodeQ500H),
    .RingInputAddressQ500H  (RingInputAddressQ500H),
    .RingInputDataQ500H     (RingInputDataQ500H),
    .RingOutputValidQ501H   (RingOutputValidQ501H),
    .RingOutputOpcodeQ501H  (RingOutputOpcodeQ501H),
    .RingOutputAddressQ501H (RingOutputAddressQ501H),
    .RingOutputDataQ501H    (RingOutputDataQ501H),
    .HostReqValid           (HostReqValid),
    .HostReqReady           (HostReqReady),
    .HostReqOpcode          (HostReqOpcode),
    .HostReqAddress         (HostReqAddress),
    .HostReqData            (HostReqData),
    .HostRspValid           (HostRspValid),
    .HostRspReady           (HostRspReady),
    .HostRspOpcode          (HostRspOpcode),
    .HostRspAddress         (HostRspAddress),
    .HostRspData            (HostRspData),
    .RecircCnt              (RecircCnt)
  );

  always #5 QClk = ~QClk;

  int cyc = 0;
  always @(posedge QClk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t ring_q[$];
  exp_t rsp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp_pkt(input string name, input exp_t e, input logic [1:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
    n_chk++;
    if (op !== e.op || addr !== e.addr || data !== e.data || (e.cyc >= 0 && e.cyc != cyc)) begin
      n_fail++;
      $display("FAIL %s: got op=%0d addr=%h data=%h cyc=%0d, required op=%0d addr=%h data=%h cyc=%0d",
               name, op, addr, data, cyc, e.op, e.addr, e.data, e.cyc);
    end
  endtask

  task automatic mon_loop();
    exp_t e;
    forever begin
      @(negedge QClk);
      if (RingOutputValidQ501H) begin
        if (ring_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ring_unexpected: got op=%0d addr=%h data=%h cyc=%0d, required no packet",
                   RingOutputOpcodeQ501H, RingOutputAddressQ501H, RingOutputDataQ501H, cyc);
        end else begin
          e = ring_q.pop_front();
          cmp_pkt("ring_pkt", e, RingOutputOpcodeQ501H, RingOutputAddressQ501H, RingOutputDataQ501H);
        end
      end
      if (HostRspValid && HostRspReady) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got op=%0d addr=%h data=%h cyc=%0d, required no response",
                   HostRspOpcode, HostRspAddress, HostRspData, cyc);
        end else begin
          e = rsp_q.pop_front();
          cmp_pkt("host_rsp", e, HostRspOpcode, HostRspAddress, HostRspData);
        end
      end
    end
  endtask

  task automatic watchdog();
    repeat (3000) @(posedge QClk);
    n_fail++;
    $display("FAIL watchdog: got no end of test after 3000 cycles, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  endtask

  task automatic step();
    @(posedge QClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    RingInputValidQ500H   = v;
    RingInputOpcodeQ500H  = op;
    RingInputAddressQ500H = a;
    RingInputDataQ500H    = d;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic host_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    HostReqValid   = 1'b1;
    HostReqOpcode  = op;
    HostReqAddress = a;
    HostReqData    = d;
  endtask

  task automatic exp_ring(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e = '{op: op, addr: a, data: d, cyc: c};
    ring_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e = '{op: op, addr: a, data: d, cyc: c};
    rsp_q.push_back(e);
  endtask

  function automatic logic [31:0] req_addr(input int j);
    return 32'h0600_0000 + 32'(j * 4);
  endfunction

  function automatic logic [31:0] req_data(input int j);
    return 32'hC000_0000 + 32'(j);
  endfunction

  initial begin
    RstQnnnL = 1'b0;
    idle();
    HostReqValid = 1'b0; HostReqOpcode = 2'b00; HostReqAddress = '0; HostReqData = '0;
    HostRspReady = 1'b1;
    fork
      mon_loop();
      watchdog();
    join_none

    #2;
    chk("rst_ring_valid", 32'(RingOutputValidQ501H), 32'd0);
    chk("rst_rsp_valid", 32'(HostRspValid), 32'd0);
    chk("rst_recirc", 32'(RecircCnt), 32'd0);
    chk("rst_req_ready", 32'(HostReqReady), 32'd1);
    repeat (3) step();
    RstQnnnL = 1'b1;
    step();

    // Pass-through of foreign traffic
    drive(1'b1, OP_RD, 32'h0200_0040, 32'h1111_2222);
    exp_ring(OP_RD, 32'h0200_0040, 32'h1111_2222, cyc + 1);
    step();
    idle();
    chk("pass_rsp_valid", 32'(HostRspValid), 32'd0);
    step();

    // Single inject then its response
    host_req(OP_WR, 32'h0300_0010, 32'hDEAD_BEEF);
    exp_ring(OP_WR, 32'h0300_0010, 32'hDEAD_BEEF, cyc + 2);
    step();
    HostReqValid = 1'b0;
    repeat (3) step();
    drive(1'b1, OP_RD_RSP, 32'hFF00_0010, 32'h0000_00AA);
    exp_rsp(OP_RD_RSP, 32'hFF00_0010, 32'h0000_00AA, cyc + 1);
    step();
    idle();
    chk("eject_rsp_valid", 32'(HostRspValid), 32'd1);
    chk("eject_rsp_data", HostRspData, 32'h0000_00AA);
    step();
    chk("eject_rsp_drained", 32'(HostRspValid), 32'd0);

    // Slot contention: FIFO fills behind 8 cycles of foreign traffic
    begin
      int c0;
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
        logic [31:0] fa;
        fa = {8'(i + 1), 24'(i * 16)};
        drive(1'b1, 2'(i % 4), fa, 32'h5000_0000 + 32'(i));
        exp_ring(2'(i % 4), fa, 32'h5000_0000 + 32'(i), cyc + 1);
        if (i < 4) host_req(OP_RD, 32'h0400_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        else HostReqValid = 1'b0;
        if (i == 4) chk("fifo_full_ready", 32'(HostReqReady), 32'd0);
        step();
      end
      idle();
      for (int j = 0; j < 4; j++)
        exp_ring(OP_RD, 32'h0400_0100 + 32'(j * 4), 32'hA000_0000 + 32'(j), c0 + 9 + j);
      repeat (6) step();
      chk("fifo_drained_ready", 32'(HostReqReady), 32'd1);
    end

    // Back-to-back ejects into a drained buffer
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, (j % 2 == 0) ? OP_RD_RSP : OP_WR_RSP, 32'hFF00_0100 + 32'(j * 4), 32'hB000_0000 + 32'(j));
      exp_rsp((j % 2 == 0) ? OP_RD_RSP : OP_WR_RSP, 32'hFF00_0100 + 32'(j * 4), 32'hB000_0000 + 32'(j), cyc + 1);
      step();
    end
    idle();
    repeat (2) step();

    // Credit limit: 6 pushes, only 4 injected
    for (int j = 0; j < 6; j++) begin
      host_req(OP_WR, req_addr(j), req_data(j));
      if (j < 4) exp_ring(OP_WR, req_addr(j), req_data(j), cyc + 2);
      step();
    end
    HostReqValid = 1'b0;
    repeat (6) step();
    drive(1'b1, OP_RD_RSP, 32'hFF00_0200, 32'h0000_0001);
    exp_rsp(OP_RD_RSP, 32'hFF00_0200, 32'h0000_0001, cyc + 1);
    step();
    drive(1'b1, OP_WR_RSP, 32'hFF00_0204, 32'h0000_0002);
    exp_rsp(OP_WR_RSP, 32'hFF00_0204, 32'h0000_0002, cyc + 1);
    exp_ring(OP_WR, req_addr(4), req_data(4), cyc + 1);
    step();
    idle();
    host_req(OP_WR, req_addr(6), req_data(6));
    exp_ring(OP_WR, req_addr(5), req_data(5), cyc + 1);
    step();
    HostReqValid = 1'b0;
    repeat (6) step();
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, OP_RD_RSP, 32'hFF00_0300 + 32'(j), 32'h0000_0010 + 32'(j));
      exp_rsp(OP_RD_RSP, 32'hFF00_0300 + 32'(j), 32'h0000_0010 + 32'(j), cyc + 1);
      if (j == 1) exp_ring(OP_WR, req_addr(6), req_data(6), cyc + 1);
      step();
    end
    idle();
    repeat (3) step();

    // Response buffer full: second response recirculates
    HostRspReady = 1'b0;
    drive(1'b1, OP_RD_RSP, 32'hFF00_0500, 32'h0000_0055);
    step();
    drive(1'b1, OP_WR_RSP, 32'hFF00_0504, 32'h0000_0066);
    exp_ring(OP_WR_RSP, 32'hFF00_0504, 32'h0000_0066, cyc + 1);
    chk("full_first_valid", 32'(HostRspValid), 32'd1);
    step();
    idle();
    chk("recirc_cnt_1", 32'(RecircCnt), 32'd1);
    repeat (3) step();
    chk("full_hold_valid", 32'(HostRspValid), 32'd1);
    chk("full_hold_data", HostRspData, 32'h0000_0055);
    exp_rsp(OP_RD_RSP, 32'hFF00_0500, 32'h0000_0055, -1);
    HostRspReady = 1'b1;
    step();
    step();
    chk("full_released", 32'(HostRspValid), 32'd0);

    // Reset mid-traffic with three queued requests
    HostRspReady = 1'b0;
    drive(1'b1, OP_RD_RSP, 32'hFF00_05F0, 32'h0000_0077);
    step();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] fa;
      fa = (i == 3) ? 32'hFF00_0600 : {8'h07, 24'(i)};
      drive(1'b1, (i == 3) ? OP_RD_RSP : OP_RD, fa, 32'h7000_0000 + 32'(i));
      if (i < 5) exp_ring((i == 3) ? OP_RD_RSP : OP_RD, fa, 32'h7000_0000 + 32'(i), cyc + 1);
      if (i < 3) host_req(OP_RD, 32'h0800_0000 + 32'(i), 32'h0);
      else HostReqValid = 1'b0;
      if (i < 5) step();
    end
    chk("pre_rst_recirc", 32'(RecircCnt), 32'd2);
    chk("pre_rst_ring_valid", 32'(RingOutputValidQ501H), 32'd1);
    #5;
    ring_q.delete();
    rsp_q.delete();
    RstQnnnL = 1'b0;
    #1;
    chk("async_rst_ring_valid", 32'(RingOutputValidQ501H), 32'd0);
    chk("async_rst_rsp_valid", 32'(HostRspValid), 32'd0);
    chk("async_rst_recirc", 32'(RecircCnt), 32'd0);
    idle();
    HostReqValid = 1'b0;
    HostRspReady = 1'b1;
    repeat (2) step();
    RstQnnnL = 1'b1;
    step();
    chk("post_rst_req_ready", 32'(HostReqReady), 32'd1);
    chk("post_rst_recirc", 32'(RecircCnt), 32'd0);

    // Stale response after reset, then full credit must still be available
    drive(1'b1, OP_WR_RSP, 32'hFF00_0700, 32'h0000_0088);
    exp_rsp(OP_WR_RSP, 32'hFF00_0700, 32'h0000_0088, cyc + 1);
    step();
    idle();
    step();
    for (int j = 0; j < 4; j++) begin
      host_req(OP_RD, 32'h0900_0000 + 32'(j * 4), 32'h0);
      exp_ring(OP_RD, 32'h0900_0000 + 32'(j * 4), 32'h0, cyc + 2);
      step();
    end
    HostReqValid = 1'b0;

    for (int n = 0; n < 20 && (ring_q.size() != 0 || rsp_q.size() != 0); n++) step();
    repeat (2) step();
    chk("ring_q_empty", 32'(ring_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
